// File: rtl/tt_um_csa_subtractor.sv
// Sequential 8-bit subtractor (A - B - bin) built from two 4-bit borrow-select
// slices, evaluated low nibble first, then high nibble, behind the TinyTapeout pinout.

module csa_sub_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic [4:0] cand0;
  logic [4:0] cand1;

  // Both borrow-in cases are formed up front; bit 4 of each is its borrow out
  assign cand0 = {1'b0, a} - {1'b0, b};
  assign cand1 = {1'b0, a} - {1'b0, b} - 5'd1;

  assign {bout, diff} = bin ? cand1 : cand0;

endmodule

module tt_um_csa_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic       bin_reg;
  logic       bl_reg;
  logic [7:0] d_reg;
  logic       bout_reg;
  logic       zero_reg;

  logic       load_a;
  logic       load_b;
  logic       start;
  logic       start_ok;
  logic       busy;
  logic       done;

  logic [3:0] lo_diff;
  logic       lo_bout;
  logic [3:0] hi_diff;
  logic       hi_bout;
  logic       unused_bits;

  assign load_a      = uio_in[0];
  assign load_b      = uio_in[1];
  assign start       = uio_in[2];
  assign unused_bits = &{1'b0, uio_in[7:4]};

  // A start that coincides with a load strobe is dropped
  assign start_ok = start & ~load_a & ~load_b;

  csa_sub_slice u_lo (
    .a    (a_reg[3:0]),
    .b    (b_reg[3:0]),
    .bin  (bin_reg),
    .diff (lo_diff),
    .bout (lo_bout)
  );

  csa_sub_slice u_hi (
    .a    (a_reg[7:4]),
    .b    (b_reg[7:4]),
    .bin  (bl_reg),
    .diff (hi_diff),
    .bout (hi_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = LO;
        end
      end
      LO: begin
        busy      = 1'b1;
        state_nxt = HI;
      end
      HI: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands only move in IDLE, so they stay put while the slices consume them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= 8'h00;
      b_reg    <= 8'h00;
      bin_reg  <= 1'b0;
      bl_reg   <= 1'b0;
      d_reg    <= 8'h00;
      bout_reg <= 1'b0;
      zero_reg <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (load_a) begin
            a_reg <= ui_in;
          end
          if (load_b) begin
            b_reg <= ui_in;
          end
          if (start_ok) begin
            bin_reg <= uio_in[3];
          end
        end
        LO: begin
          d_reg[3:0] <= lo_diff;
          bl_reg     <= lo_bout;
        end
        HI: begin
          d_reg[7:4] <= hi_diff;
          bout_reg   <= hi_bout;
          zero_reg   <= ({hi_diff, d_reg[3:0]} == 8'h00);
        end
        default: begin
        end
      endcase
    end
  end

  assign uo_out  = d_reg;
  assign uio_out = {zero_reg, bout_reg, done, busy, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_csa_subtractor.sv
// Directed self-checking bench for tt_um_csa_subtractor: arithmetic, borrow
// chaining, protocol guards, async reset and enable stalls.

module tb_tt_um_csa_subtractor;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total;
  int bad;

  tt_um_csa_subtractor dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic [7:0] ctrl);
    ui_in  = data;
    uio_in = ctrl;
    tick();
    ui_in  = 8'h00;
    uio_in = 8'h00;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Loads both operands, starts, and checks the whole 3-cycle sequence
  task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] exp_d,
                       input logic exp_bout, input logic exp_zero);
    applyStimulus(a, 8'h01);
    applyStimulus(b, 8'h02);
    applyStimulus(8'h00, {4'b0000, bin, 3'b100});
    checkOutput({tag, "_busy"}, {7'd0, uio_out[4]}, 8'h01);
    checkOutput({tag, "_nodone"}, {7'd0, uio_out[5]}, 8'h00);
    tick();
    checkOutput({tag, "_lonib"}, {4'h0, uo_out[3:0]}, {4'h0, exp_d[3:0]});
    tick();
    checkOutput({tag, "_done"}, {7'd0, uio_out[5]}, 8'h01);
    checkOutput({tag, "_idle_busy"}, {7'd0, uio_out[4]}, 8'h00);
    checkOutput({tag, "_d"}, uo_out, exp_d);
    checkOutput({tag, "_bout"}, {7'd0, uio_out[6]}, {7'd0, exp_bout});
    checkOutput({tag, "_zero"}, {7'd0, uio_out[7]}, {7'd0, exp_zero});
    tick();
    checkOutput({tag, "_donepulse"}, {7'd0, uio_out[5]}, 8'h00);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #2;
    checkOutput("rst_uo", uo_out, 8'h00);
    checkOutput("rst_uio", uio_out, 8'h00);
    checkOutput("rst_oe", uio_oe, 8'hF0);
    #20;
    rst_n = 1'b1;
    tick();

    runOp("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    runOp("chain0", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    runOp("chain1", 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0);
    runOp("under", 8'h00, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0);
    runOp("zero", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);

    // start with load_a: load happens, start does not
    applyStimulus(8'h33, 8'h05);
    checkOutput("guard_ld_start_busy", {7'd0, uio_out[4]}, 8'h00);
    tick();
    checkOutput("guard_ld_start_still", {7'd0, uio_out[4]}, 8'h00);
    checkOutput("guard_ld_start_d", uo_out, 8'h00);
    applyStimulus(8'h03, 8'h02);
    applyStimulus(8'h00, 8'h04);
    tick();
    tick();
    checkOutput("guard_ld_start_res", uo_out, 8'h30);
    tick();

    // load while busy is ignored; start during DONE is ignored
    applyStimulus(8'h20, 8'h01);
    applyStimulus(8'h05, 8'h02);
    applyStimulus(8'h00, 8'h04);
    applyStimulus(8'hAA, 8'h01);
    tick();
    checkOutput("busyload_done", {7'd0, uio_out[5]}, 8'h01);
    checkOutput("busyload_d", uo_out, 8'h1B);
    applyStimulus(8'h00, 8'h04);
    checkOutput("donestart_busy", {7'd0, uio_out[4]}, 8'h00);
    tick();
    checkOutput("donestart_idle", {7'd0, uio_out[4]}, 8'h00);
    applyStimulus(8'h00, 8'h04);
    tick();
    tick();
    checkOutput("busyload_keepA", uo_out, 8'h1B);
    tick();

    // async reset while in HI
    applyStimulus(8'h5A, 8'h01);
    applyStimulus(8'h3C, 8'h02);
    applyStimulus(8'h00, 8'h04);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_uo", uo_out, 8'h00);
    checkOutput("midrst_uio", uio_out, 8'h00);
    checkOutput("midrst_oe", uio_oe, 8'hF0);
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("postrst_busy", {7'd0, uio_out[4]}, 8'h00);
    checkOutput("postrst_uo", uo_out, 8'h00);
    // A and B were cleared, so 0 - 0 - 1 wraps
    applyStimulus(8'h00, 8'h0C);
    tick();
    tick();
    checkOutput("postrst_res", uo_out, 8'hFF);
    checkOutput("postrst_bout", {7'd0, uio_out[6]}, 8'h01);
    tick();

    // ena low for two cycles while in LO
    applyStimulus(8'h10, 8'h01);
    applyStimulus(8'h01, 8'h02);
    applyStimulus(8'h00, 8'h0C);
    ena = 1'b0;
    tick();
    tick();
    checkOutput("ena_hold_busy", {7'd0, uio_out[4]}, 8'h01);
    checkOutput("ena_hold_d", uo_out, 8'hFF);
    ena = 1'b1;
    tick();
    checkOutput("ena_lonib", {4'h0, uo_out[3:0]}, 8'h0E);
    checkOutput("ena_nodone", {7'd0, uio_out[5]}, 8'h00);
    tick();
    checkOutput("ena_done", {7'd0, uio_out[5]}, 8'h01);
    checkOutput("ena_d", uo_out, 8'h0E);
    tick();
    checkOutput("ena_donepulse", {7'd0, uio_out[5]}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
